// File: rtl/rv32i_types_pkg.sv
// Scalar RV32I base types shared by the integer and vector pipelines.
package rv32i_types_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

endpackage : rv32i_types_pkg

// File: rtl/rv32v_types_pkg.sv
// Vector-unit types: lane/vl sizing, element width encoding, writeback sequencer state.
package rv32v_types_pkg;

    localparam int NUM_LANES = 2;
    localparam int VL_WIDTH  = 5;

    // Element index inside a vector register group; vl itself needs one more bit.
    typedef logic [VL_WIDTH-1:0] offset_t;
    typedef logic [VL_WIDTH:0]   vl_t;

    typedef enum logic [1:0] {
        SEW32 = 2'd0,
        SEW16 = 2'd1,
        SEW8  = 2'd2
    } sew_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } wb_state_t;

endpackage : rv32v_types_pkg

// File: rtl/rv32v_wb_sequencer.sv
// Vector writeback sequencer: turns a (vd, sew, vl) descriptor plus a stream of result beats
// into registered register-file writes. Optional RV32V_WB_TAIL_ZERO_EN zeroes lanes past vl.
module rv32v_wb_sequencer
    import rv32i_types_pkg::word_t;
    import rv32v_types_pkg::sew_t;
    import rv32v_types_pkg::offset_t;
    import rv32v_types_pkg::wb_state_t;
    import rv32v_types_pkg::IDLE;
    import rv32v_types_pkg::RUN;
    import rv32v_types_pkg::DONE;
    import rv32v_types_pkg::SEW32;
#(
    parameter int NUM_LANES = rv32v_types_pkg::NUM_LANES,
    parameter int VL_WIDTH  = rv32v_types_pkg::VL_WIDTH
) (
    input  logic                        CLK,
    input  logic                        RST,

    input  logic                        start_valid,
    output logic                        start_ready,
    input  logic [4:0]                  start_vd,
    input  sew_t                        start_sew,
    input  logic [VL_WIDTH:0]           start_vl,

    input  logic                        res_valid,
    output logic                        res_ready,
    input  word_t [NUM_LANES-1:0]       res_data,

    input  logic                        flush,

    output word_t [NUM_LANES-1:0]       wb_w_data,
    output logic [4:0]                  wb_vd,
    output logic                        wb_wen,
    output offset_t                     wb_vd_offset,
    output sew_t                        wb_sew,
    output logic [VL_WIDTH:0]           wb_vl,

    output logic                        busy,
    output logic                        done
);

    // Two extra bits so offset + NUM_LANES can never wrap before comparing against vl.
    localparam int CW = VL_WIDTH + 2;

    wb_state_t             state_q;
    wb_state_t             state_d;
    offset_t               offset_q;
    logic                  start_hs;
    logic                  res_hs;
    logic                  last_beat;
    logic [CW-1:0]         next_off_ext;
    word_t [NUM_LANES-1:0] lane_data;

    assign start_hs     = start_valid && start_ready;
    assign res_hs       = res_valid && res_ready;
    assign next_off_ext = CW'(offset_q) + CW'(NUM_LANES);
    assign last_beat    = next_off_ext >= CW'(wb_vl);

    // NOTE: state register uses non-blocking assignment; all decode lives in the always_comb below.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        start_ready = 1'b0;
        res_ready   = 1'b0;
        done        = 1'b0;
        busy        = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    state_d = (start_vl == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                res_ready = 1'b1;
                if (res_valid && last_beat) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Abort wins over any handshake seen in the same cycle.
        if (flush) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        lane_data = res_data;
`ifdef RV32V_WB_TAIL_ZERO_EN
        for (int i = 0; i < NUM_LANES; i++) begin
            if (CW'(offset_q) + CW'(i) >= CW'(wb_vl)) begin
                lane_data[i] = '0;
            end
        end
`endif
    end

    // Descriptor registers double as the RF-facing wb_vd/wb_sew/wb_vl and keep their value in IDLE.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wb_wen       <= 1'b0;
            wb_w_data    <= '0;
            wb_vd        <= '0;
            wb_vd_offset <= '0;
            wb_sew       <= SEW32;
            wb_vl        <= '0;
            offset_q     <= '0;
        end else begin
            wb_wen <= res_hs && !flush;
            if (start_hs && !flush) begin
                wb_vd    <= start_vd;
                wb_sew   <= start_sew;
                wb_vl    <= start_vl;
                offset_q <= '0;
            end
            if (res_hs && !flush) begin
                wb_w_data    <= lane_data;
                wb_vd_offset <= offset_q;
                offset_q     <= offset_q + offset_t'(NUM_LANES);
            end
        end
    end

endmodule : rv32v_wb_sequencer

// File: tb/tb_rv32v_wb_sequencer.sv
// Directed self-checking bench for rv32v_wb_sequencer (NUM_LANES=2, VL_WIDTH=5).
module tb_rv32v_wb_sequencer;
    import rv32i_types_pkg::*;
    import rv32v_types_pkg::*;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         start_valid = 1'b0;
    logic         start_ready;
    logic [4:0]   start_vd = '0;
    sew_t         start_sew = SEW32;
    logic [5:0]   start_vl = '0;
    logic         res_valid = 1'b0;
    logic         res_ready;
    word_t [1:0]  res_data = '0;
    logic         flush = 1'b0;
    word_t [1:0]  wb_w_data;
    logic [4:0]   wb_vd;
    logic         wb_wen;
    offset_t      wb_vd_offset;
    sew_t         wb_sew;
    logic [5:0]   wb_vl;
    logic         busy;
    logic         done;

    int n_asserts = 0;
    int n_fail    = 0;

    rv32v_wb_sequencer #(.NUM_LANES(2), .VL_WIDTH(5)) dut (
        .CLK(CLK), .RST(RST),
        .start_valid(start_valid), .start_ready(start_ready), .start_vd(start_vd),
        .start_sew(start_sew), .start_vl(start_vl),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .flush(flush),
        .wb_w_data(wb_w_data), .wb_vd(wb_vd), .wb_wen(wb_wen), .wb_vd_offset(wb_vd_offset),
        .wb_sew(wb_sew), .wb_vl(wb_vl), .busy(busy), .done(done)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string pfx);
        chk({pfx, "_wen"},         64'(wb_wen),       64'd0);
        chk({pfx, "_done"},        64'(done),         64'd0);
        chk({pfx, "_busy"},        64'(busy),         64'd0);
        chk({pfx, "_wdata"},       64'(wb_w_data),    64'd0);
        chk({pfx, "_vd"},          64'(wb_vd),        64'd0);
        chk({pfx, "_offset"},      64'(wb_vd_offset), 64'd0);
        chk({pfx, "_sew"},         64'(wb_sew),       64'd0);
        chk({pfx, "_vl"},          64'(wb_vl),        64'd0);
        chk({pfx, "_start_ready"}, 64'(start_ready),  64'd1);
        chk({pfx, "_res_ready"},   64'(res_ready),    64'd0);
    endtask

    task automatic drive_start(input logic [4:0] vd, input sew_t sew, input logic [5:0] vl);
        start_valid = 1'b1;
        start_vd    = vd;
        start_sew   = sew;
        start_vl    = vl;
    endtask

    task automatic drive_beat(input logic [31:0] lane1, input logic [31:0] lane0);
        res_valid   = 1'b1;
        res_data[1] = lane1;
        res_data[0] = lane0;
    endtask

    task automatic drive_quiet();
        start_valid = 1'b0;
        res_valid   = 1'b0;
        flush       = 1'b0;
    endtask

    initial begin
        // Reset
        repeat (2) @(negedge CLK);
        chk_reset("rst");
        RST = 1'b0;

        // T1: vd=3 sew=32 vl=5, continuous beats -> offsets 0,2,4, done with third write
        @(negedge CLK);
        drive_start(5'd3, SEW32, 6'd5);
        @(negedge CLK);
        chk("t1_busy",        64'(busy),        64'd1);
        chk("t1_res_ready",   64'(res_ready),   64'd1);
        chk("t1_start_ready", 64'(start_ready), 64'd0);
        chk("t1_wen0",        64'(wb_wen),      64'd0);
        chk("t1_vd",          64'(wb_vd),       64'd3);
        chk("t1_vl",          64'(wb_vl),       64'd5);
        drive_quiet();
        drive_beat(32'h1111_0001, 32'h1111_0000);
        @(negedge CLK);
        chk("t1_b0_wen",  64'(wb_wen),       64'd1);
        chk("t1_b0_off",  64'(wb_vd_offset), 64'd0);
        chk("t1_b0_data", 64'(wb_w_data),    64'h1111_0001_1111_0000);
        chk("t1_b0_done", 64'(done),         64'd0);
        drive_beat(32'h2222_0003, 32'h2222_0002);
        @(negedge CLK);
        chk("t1_b1_wen",  64'(wb_wen),       64'd1);
        chk("t1_b1_off",  64'(wb_vd_offset), 64'd2);
        chk("t1_b1_data", 64'(wb_w_data),    64'h2222_0003_2222_0002);
        chk("t1_b1_done", 64'(done),         64'd0);
        drive_beat(32'h3333_0005, 32'h3333_0004);
        @(negedge CLK);
        chk("t1_b2_wen",  64'(wb_wen),       64'd1);
        chk("t1_b2_off",  64'(wb_vd_offset), 64'd4);
        chk("t1_b2_done", 64'(done),         64'd1);
        chk("t1_b2_res_ready", 64'(res_ready), 64'd0);
`ifdef RV32V_WB_TAIL_ZERO_EN
        chk("t1_b2_data", 64'(wb_w_data),    64'h0000_0000_3333_0004);
`else
        chk("t1_b2_data", 64'(wb_w_data),    64'h3333_0005_3333_0004);
`endif
        drive_quiet();
        @(negedge CLK);
        chk("t1_end_wen",   64'(wb_wen),      64'd0);
        chk("t1_end_done",  64'(done),        64'd0);
        chk("t1_end_busy",  64'(busy),        64'd0);
        chk("t1_end_ready", 64'(start_ready), 64'd1);
        chk("t1_end_vd",    64'(wb_vd),       64'd3);

        // T2: vl=0 -> done one cycle after start, no writes
        drive_start(5'd6, SEW8, 6'd0);
        @(negedge CLK);
        drive_quiet();
        chk("t2_done",        64'(done),        64'd1);
        chk("t2_wen",         64'(wb_wen),      64'd0);
        chk("t2_start_ready", 64'(start_ready), 64'd0);
        chk("t2_busy",        64'(busy),        64'd1);
        chk("t2_res_ready",   64'(res_ready),   64'd0);
        @(negedge CLK);
        chk("t2_idle_done",  64'(done),        64'd0);
        chk("t2_idle_ready", 64'(start_ready), 64'd1);
        chk("t2_idle_wen",   64'(wb_wen),      64'd0);

        // T3: vl=4 sew=16 with a res_valid gap -> writes at offsets 0,2 only after handshakes
        drive_start(5'd10, SEW16, 6'd4);
        @(negedge CLK);
        drive_quiet();
        chk("t3_sew", 64'(wb_sew), 64'(SEW16));
        drive_beat(32'hA000_0001, 32'hA000_0000);
        @(negedge CLK);
        chk("t3_b0_wen", 64'(wb_wen),       64'd1);
        chk("t3_b0_off", 64'(wb_vd_offset), 64'd0);
        res_valid = 1'b0;
        @(negedge CLK);
        chk("t3_gap_wen",  64'(wb_wen), 64'd0);
        chk("t3_gap_done", 64'(done),   64'd0);
        chk("t3_gap_busy", 64'(busy),   64'd1);
        drive_beat(32'hB000_0003, 32'hB000_0002);
        @(negedge CLK);
        chk("t3_b1_wen",  64'(wb_wen),       64'd1);
        chk("t3_b1_off",  64'(wb_vd_offset), 64'd2);
        chk("t3_b1_data", 64'(wb_w_data),    64'hB000_0003_B000_0002);
        chk("t3_b1_done", 64'(done),         64'd1);
        drive_quiet();
        @(negedge CLK);
        chk("t3_end_busy", 64'(busy), 64'd0);

        // T4: vl=8, flush alongside the second beat -> one write, no done, new start accepted
        drive_start(5'd7, SEW32, 6'd8);
        @(negedge CLK);
        drive_quiet();
        drive_beat(32'hC000_0001, 32'hC000_0000);
        @(negedge CLK);
        chk("t4_b0_wen", 64'(wb_wen),       64'd1);
        chk("t4_b0_off", 64'(wb_vd_offset), 64'd0);
        drive_beat(32'hD000_0003, 32'hD000_0002);
        flush = 1'b1;
        #1;
        chk("t4_flush_res_ready", 64'(res_ready), 64'd1);
        @(negedge CLK);
        chk("t4_fl_wen",   64'(wb_wen),       64'd0);
        chk("t4_fl_done",  64'(done),         64'd0);
        chk("t4_fl_busy",  64'(busy),         64'd0);
        chk("t4_fl_ready", 64'(start_ready),  64'd1);
        chk("t4_fl_data",  64'(wb_w_data),    64'hC000_0001_C000_0000);
        drive_quiet();
        drive_start(5'd9, SEW32, 6'd2);
        @(negedge CLK);
        drive_quiet();
        chk("t4_re_busy", 64'(busy),  64'd1);
        chk("t4_re_vd",   64'(wb_vd), 64'd9);
        drive_beat(32'hE000_0001, 32'hE000_0000);
        @(negedge CLK);
        chk("t4_re_wen",  64'(wb_wen),       64'd1);
        chk("t4_re_off",  64'(wb_vd_offset), 64'd0);
        chk("t4_re_done", 64'(done),         64'd1);
        drive_quiet();
        @(negedge CLK);

        // T5: vl=6, reset after first write -> reset values at once; then vl=2 runs cleanly
        drive_start(5'd4, SEW8, 6'd6);
        @(negedge CLK);
        drive_quiet();
        drive_beat(32'hF000_0001, 32'hF000_0000);
        @(negedge CLK);
        chk("t5_b0_wen", 64'(wb_wen), 64'd1);
        drive_beat(32'hF000_0003, 32'hF000_0002);
        #2;
        RST = 1'b1;
        #1;
        chk_reset("t5_rst");
        @(negedge CLK);
        drive_quiet();
        RST = 1'b0;
        drive_start(5'd5, SEW32, 6'd2);
        @(negedge CLK);
        drive_quiet();
        chk("t5_post_busy", 64'(busy),   64'd1);
        chk("t5_post_wen",  64'(wb_wen), 64'd0);
        drive_beat(32'h5555_0001, 32'h5555_0000);
        @(negedge CLK);
        chk("t5_post_b0_wen",  64'(wb_wen),       64'd1);
        chk("t5_post_b0_off",  64'(wb_vd_offset), 64'd0);
        chk("t5_post_b0_done", 64'(done),         64'd1);
        chk("t5_post_b0_data", 64'(wb_w_data),    64'h5555_0001_5555_0000);
        drive_quiet();
        @(negedge CLK);

        // T6: back-to-back vd=1 vl=2 then vd=2 vl=2 -> one idle bubble between them
        drive_start(5'd1, SEW32, 6'd2);
        @(negedge CLK);
        drive_quiet();
        drive_beat(32'h0101_0001, 32'h0101_0000);
        @(negedge CLK);
        chk("t6_a_done", 64'(done),  64'd1);
        chk("t6_a_vd",   64'(wb_vd), 64'd1);
        chk("t6_a_start_ready_in_done", 64'(start_ready), 64'd0);
        drive_quiet();
        drive_start(5'd2, SEW32, 6'd2);
        @(negedge CLK);
        chk("t6_bubble_ready", 64'(start_ready), 64'd1);
        chk("t6_bubble_busy",  64'(busy),        64'd0);
        chk("t6_bubble_vd",    64'(wb_vd),       64'd1);
        @(negedge CLK);
        drive_quiet();
        chk("t6_b_busy", 64'(busy),  64'd1);
        chk("t6_b_vd",   64'(wb_vd), 64'd2);
        drive_beat(32'h0202_0001, 32'h0202_0000);
        @(negedge CLK);
        chk("t6_b_wen",  64'(wb_wen),       64'd1);
        chk("t6_b_off",  64'(wb_vd_offset), 64'd0);
        chk("t6_b_done", 64'(done),         64'd1);
        drive_quiet();
        @(negedge CLK);
        chk("t6_end_busy", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule : tb_rv32v_wb_sequencer
